// File: rtl/ifetch_pkg.sv
// Shared definitions for the fetch stage and the control decoder: FSM states,
// opcode encodings and instruction field positions.
package ifetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] OPC_NOP   = 4'h0;
   localparam logic [3:0] OPC_JUMP  = 4'h1;
   localparam logic [3:0] OPC_SAVE  = 4'h2;
   localparam logic [3:0] OPC_LOAD  = 4'h3;
   localparam logic [3:0] OPC_LOADI = 4'h4;
   localparam logic [3:0] OPC_SLL   = 4'h5;
   localparam logic [3:0] OPC_ADD   = 4'h8;
   localparam logic [3:0] OPC_SUB   = 4'h9;
   localparam logic [3:0] OPC_AND   = 4'hA;
   localparam logic [3:0] OPC_OR    = 4'hB;
   localparam logic [3:0] OPC_XOR   = 4'hC;
   localparam logic [3:0] OPC_SLT   = 4'hE;
   localparam logic [3:0] OPC_BZ    = 4'hF;

   localparam logic [7:0] OP_FIELD_NOP = 8'h00;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 8;
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

endpackage

// File: rtl/op_legal.sv
// Combinational opcode legality check; zero latency, no handshake.
// Only instantiated by ifetch when IFETCH_TRAP_EN is defined.
module op_legal
   import ifetch_pkg::*;
(
   input  logic [3:0] i_opcode,
   output logic       o_legal
);

   always_comb begin
      o_legal = 1'b0;
      case (i_opcode)
         OPC_NOP, OPC_JUMP, OPC_SAVE, OPC_LOAD, OPC_LOADI, OPC_SLL,
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SLT, OPC_BZ: o_legal = 1'b1;
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, req/ack imem port, valid/ready hand-off to decode; valid one cycle after ack,
// output held while ready is low. IFETCH_TRAP_EN adds illegal-opcode trapping and the o_illegal port.
module ifetch
   import ifetch_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [15:0]       i_imem_rdata,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_addr,
   output logic [7:0]        o_op,
   output logic [7:0]        o_imm,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_valid,
   input  logic              i_ready
`ifdef IFETCH_TRAP_EN
   ,
   output logic              o_illegal
`endif
);

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pend;
   logic              r_req;
   logic              r_valid;
   logic [7:0]        r_op;
   logic [7:0]        r_imm;
   logic [ADDR_W-1:0] r_pc_out;

   logic [7:0]        w_op_fetch;
   logic              w_accept;
   logic              w_consume;

   // r_req is low only in the first REQ cycle after reset, so an ack there is ignored.
   assign w_accept  = (r_state == ST_REQ) && r_req && i_imem_ack && !i_redirect;
   assign w_consume = (r_state == ST_HOLD) && (i_ready || i_redirect);

`ifdef IFETCH_TRAP_EN
   logic w_legal;
   logic r_illegal;

   op_legal u_op_legal (
      .i_opcode (i_imem_rdata[OPC_HI:OPC_LO]),
      .o_legal  (w_legal)
   );

   assign w_op_fetch = w_legal ? i_imem_rdata[OP_HI:OP_LO] : OP_FIELD_NOP;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_illegal <= !w_legal;
      end else if (w_consume) begin
         r_illegal <= 1'b0;
      end
   end

   assign o_illegal = r_illegal;
`else
   assign w_op_fetch = i_imem_rdata[OP_HI:OP_LO];
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_REQ;
         r_pc     <= PC_RST;
         r_pend   <= PC_RST;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
         r_op     <= 8'h00;
         r_imm    <= 8'h00;
         r_pc_out <= PC_RST;
      end else begin
         case (r_state)
            ST_REQ: begin
               if (!r_req) begin
                  r_req <= 1'b1;
                  if (i_redirect) r_pc <= i_redirect_addr;
               end else if (w_accept) begin
                  r_op     <= w_op_fetch;
                  r_imm    <= i_imem_rdata[IMM_HI:IMM_LO];
                  r_pc_out <= r_pc;
                  r_pc     <= r_pc + ADDR_W'(1);
                  r_valid  <= 1'b1;
                  r_req    <= 1'b0;
                  r_state  <= ST_HOLD;
               end else if (i_imem_ack) begin
                  r_pc <= i_redirect_addr;
               end else if (i_redirect) begin
                  // Memory cannot abort: keep requesting the old PC and drop its data.
                  r_pend  <= i_redirect_addr;
                  r_state <= ST_DRAIN;
               end
            end
            ST_HOLD: begin
               if (w_consume) begin
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_state <= ST_REQ;
                  if (i_redirect) r_pc <= i_redirect_addr;
               end
            end
            ST_DRAIN: begin
               if (i_imem_ack) begin
                  r_pc    <= i_redirect ? i_redirect_addr : r_pend;
                  r_state <= ST_REQ;
               end else if (i_redirect) begin
                  r_pend <= i_redirect_addr;
               end
            end
            default: r_state <= ST_REQ;
         endcase
      end
   end

   assign o_imem_req  = r_req;
   assign o_imem_addr = r_pc;
   assign o_op        = r_op;
   assign o_imm       = r_imm;
   assign o_pc        = r_pc_out;
   assign o_valid     = r_valid;

endmodule

// File: tb/tb_ifetch.sv
// Directed scenarios followed by a randomized run against a transaction-level fetch model.
module tb_ifetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        redirect;
   logic [7:0]  redirect_addr;
   logic [7:0]  op;
   logic [7:0]  imm;
   logic [7:0]  pc;
   logic        valid;
   logic        ready;
   logic        illegal;

   int errors = 0;
   int checks = 0;

   ifetch #(.ADDR_W(8), .RESET_PC('h10)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .o_imem_req      (imem_req),
      .o_imem_addr     (imem_addr),
      .i_imem_ack      (imem_ack),
      .i_imem_rdata    (imem_rdata),
      .i_redirect      (redirect),
      .i_redirect_addr (redirect_addr),
      .o_op            (op),
      .o_imm           (imm),
      .o_pc            (pc),
      .o_valid         (valid),
      .i_ready         (ready)
`ifdef IFETCH_TRAP_EN
      ,
      .o_illegal       (illegal)
`endif
   );

`ifndef IFETCH_TRAP_EN
   assign illegal = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Opcodes 6, 7 and D are trapped to NOP only when the trap feature is built in.
   function automatic logic is_ill(input logic [15:0] w);
      logic [3:0] o;
      o = w[15:12];
`ifdef IFETCH_TRAP_EN
      return (o == 4'h6) || (o == 4'h7) || (o == 4'hD);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] exp_op(input logic [15:0] w);
      logic [7:0] f;
      f = w[15:8];
      return is_ill(w) ? 8'h00 : f;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; redirect = 1'b0;
      redirect_addr = 8'h0; ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", valid); end
      checks++; if (op !== 8'h00 || imm !== 8'h00) begin errors++; $display("FAIL reset_opimm got=%h/%h exp=00/00", op, imm); end
      checks++; if (pc !== 8'h10) begin errors++; $display("FAIL reset_pc got=%h exp=10", pc); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%0h exp=0", illegal); end
      rst_n = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin errors++; $display("FAIL first_req got=%0h@%h exp=1@10", imem_req, imem_addr); end
   endtask

   task automatic test_fetch();
      repeat (2) begin
         step();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h10 || valid !== 1'b0) begin
            errors++; $display("FAIL fetch_wait got req=%0h addr=%h valid=%0h exp 1/10/0", imem_req, imem_addr, valid); end
      end
      imem_ack = 1'b1; imem_rdata = 16'h8005;
      step();
      imem_ack = 1'b0; imem_rdata = 16'hxxxx;
      checks++; if (valid !== 1'b1 || op !== 8'h80 || imm !== 8'h05 || pc !== 8'h10) begin
         errors++; $display("FAIL fetch_present got v=%0h op=%h imm=%h pc=%h exp 1/80/05/10", valid, op, imm, pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got=%0h exp=0", imem_req); end
   endtask

   task automatic test_stall();
      ready = 1'b0;
      repeat (5) begin
         step();
         checks++; if (valid !== 1'b1 || op !== 8'h80 || imm !== 8'h05 || pc !== 8'h10 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_hold got v=%0h op=%h imm=%h pc=%h req=%0h exp 1/80/05/10/0", valid, op, imm, pc, imem_req); end
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h11) begin
         errors++; $display("FAIL stall_release got v=%0h req=%0h addr=%h exp 0/1/11", valid, imem_req, imem_addr); end
   endtask

   task automatic test_redirect_req();
      redirect = 1'b1; redirect_addr = 8'h40;
      step();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h11) begin
         errors++; $display("FAIL drain_addr got req=%0h addr=%h exp 1/11", imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 16'h1234;
      step();
      imem_ack = 1'b0;
      checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
         errors++; $display("FAIL drain_drop got v=%0h req=%0h addr=%h exp 0/1/40", valid, imem_req, imem_addr); end
   endtask

   task automatic test_redirect_hold();
      imem_ack = 1'b1; imem_rdata = 16'h9077;
      step();
      imem_ack = 1'b0;
      checks++; if (valid !== 1'b1 || pc !== 8'h40 || op !== 8'h90 || imm !== 8'h77) begin
         errors++; $display("FAIL hold_present got v=%0h pc=%h op=%h imm=%h exp 1/40/90/77", valid, pc, op, imm); end
      ready = 1'b1; redirect = 1'b1; redirect_addr = 8'h20;
      step();
      ready = 1'b0; redirect = 1'b0;
      checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h20) begin
         errors++; $display("FAIL hold_redirect got v=%0h req=%0h addr=%h exp 0/1/20", valid, imem_req, imem_addr); end
      repeat (2) begin
         step();
         checks++; if (valid !== 1'b0 || imem_addr !== 8'h20) begin
            errors++; $display("FAIL hold_no_dup got v=%0h addr=%h exp 0/20", valid, imem_addr); end
      end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_addr = 8'hFF; imem_ack = 1'b1; imem_rdata = 16'h1111;
      step();
      redirect = 1'b0; imem_ack = 1'b0;
      checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'hFF) begin
         errors++; $display("FAIL ack_redirect got v=%0h req=%0h addr=%h exp 0/1/ff", valid, imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 16'h2233;
      step();
      imem_ack = 1'b0;
      checks++; if (valid !== 1'b1 || pc !== 8'hFF || op !== 8'h22) begin
         errors++; $display("FAIL wrap_present got v=%0h pc=%h op=%h exp 1/ff/22", valid, pc, op); end
      ready = 1'b1;
      step();
      ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errors++; $display("FAIL wrap_addr got req=%0h addr=%h exp 1/00", imem_req, imem_addr); end
   endtask

   task automatic test_trap();
      logic [7:0] eop;
      logic       eill;
      eop  = exp_op(16'hD0AA);
      eill = is_ill(16'hD0AA);
      imem_ack = 1'b1; imem_rdata = 16'hD0AA;
      step();
      imem_ack = 1'b0;
      checks++; if (valid !== 1'b1 || op !== eop || imm !== 8'hAA) begin
         errors++; $display("FAIL trap_word got v=%0h op=%h imm=%h exp 1/%h/aa", valid, op, imm, eop); end
      checks++; if (illegal !== eill) begin errors++; $display("FAIL trap_flag got=%0h exp=%0h", illegal, eill); end
      ready = 1'b1;
      step();
      ready = 1'b0;
      checks++; if (illegal !== 1'b0 || valid !== 1'b0) begin
         errors++; $display("FAIL trap_clear got ill=%0h v=%0h exp 0/0", illegal, valid); end
   endtask

   task automatic test_reset_midfetch();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_pre got=%0h exp=1", imem_req); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || valid !== 1'b0 || pc !== 8'h10) begin
         errors++; $display("FAIL midfetch_async got req=%0h v=%0h pc=%h exp 0/0/10", imem_req, valid, pc); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
         errors++; $display("FAIL midfetch_restart got req=%0h addr=%h exp 1/10", imem_req, imem_addr); end
   endtask

   // Model: either one request outstanding (with optional pending redirect) or one instruction held.
   task automatic test_random();
      logic [15:0] mem [0:255];
      logic [7:0]  m_addr;
      logic [7:0]  m_pend;
      logic        m_dirty;
      logic        m_holding;
      logic [7:0]  h_pc;
      logic [15:0] h_word;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      m_addr = 8'h10; m_pend = 8'h00; m_dirty = 1'b0; m_holding = 1'b0;
      h_pc = 8'h00; h_word = 16'h0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         checks++; if (valid !== m_holding || imem_req !== !m_holding) begin
            errors++; $display("FAIL rnd_state cyc=%0d got v=%0h req=%0h exp v=%0h", cyc, valid, imem_req, m_holding); end
         if (!m_holding) begin
            checks++; if (imem_addr !== m_addr) begin
               errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_addr); end
         end else begin
            checks++; if (pc !== h_pc || op !== exp_op(h_word) || imm !== h_word[7:0]) begin
               errors++; $display("FAIL rnd_instr cyc=%0d got pc=%h op=%h imm=%h exp %h/%h/%h", cyc, pc, op, imm, h_pc, exp_op(h_word), h_word[7:0]); end
         end
         checks++; if (illegal !== (m_holding && is_ill(h_word))) begin
            errors++; $display("FAIL rnd_illegal cyc=%0d got=%0h exp=%0h", cyc, illegal, m_holding && is_ill(h_word)); end

         imem_ack      = !m_holding && ($urandom_range(2) == 0);
         imem_rdata    = imem_ack ? mem[imem_addr] : 16'($urandom);
         ready         = 1'($urandom);
         redirect      = ($urandom_range(7) == 0);
         redirect_addr = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);

         if (m_holding) begin
            if (redirect) begin
               m_holding = 1'b0; m_addr = redirect_addr;
            end else if (ready) begin
               m_holding = 1'b0;
            end
         end else begin
            if (redirect) begin
               m_dirty = 1'b1; m_pend = redirect_addr;
            end
            if (imem_ack) begin
               if (m_dirty) begin
                  m_addr = m_pend; m_dirty = 1'b0;
               end else begin
                  h_pc = m_addr; h_word = mem[m_addr];
                  m_addr = m_addr + 8'd1; m_holding = 1'b1;
               end
            end
         end
         step();
      end
      imem_ack = 1'b0; redirect = 1'b0; ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_redirect_req();
      test_redirect_hold();
      test_wrap();
      test_trap();
      test_reset_midfetch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule
